// File: rtl/bus2ram_slave_pkg.sv
// Shared bus types and helpers for the bus-to-SRAM slave.
//   Bus               : command and response encodings seen on the on-chip bus.
//   bus2ram_slave_pkg : width helpers used when sizing ports and entries.
package Bus;
    // Encodings 3..7 are legal on the wire and are answered with ERR.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2
    } Cmd;

    typedef enum logic [1:0] {
        NULL = 2'd0,
        DVA  = 2'd1,
        ERR  = 2'd3
    } Resp;
endpackage

package bus2ram_slave_pkg;
    localparam int RESP_W = $bits(Bus::Resp);

    // Number of byte lanes for a given data width.
    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction
endpackage

// File: rtl/bus2ram_slave_if.sv
// Bus interface between the bus master and the SRAM slave.
//   master: drives MCmd/MAddr/MData/MByteEn/MRespAccept, sees SCmdAccept/SResp/SData.
//   slave : the mirror image.
interface bus2ram_slave_if
    import bus2ram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    Bus::Cmd                       MCmd;
    logic [ADDR_WIDTH-1:0]         MAddr;
    logic [DATA_WIDTH-1:0]         MData;
    logic [be_width(DATA_WIDTH)-1:0] MByteEn;
    logic                          MRespAccept;
    logic                          SCmdAccept;
    Bus::Resp                      SResp;
    logic [DATA_WIDTH-1:0]         SData;

    modport master (
        output MCmd, MAddr, MData, MByteEn, MRespAccept,
        input  SCmdAccept, SResp, SData
    );

    modport slave (
        input  MCmd, MAddr, MData, MByteEn, MRespAccept,
        output SCmdAccept, SResp, SData
    );
endinterface

// File: rtl/bus2ram_resp_fifo.sv
// Response FIFO with fall-through head.
//   push/wdata : enqueue an entry
//   pop        : consume the head (only meaningful while valid)
//   rdata/valid: head entry; when empty a same-cycle push is shown directly
//   full/empty/count: stored-entry occupancy
module bus2ram_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 34
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             store, deq;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
        count = count_q;
        valid = !empty || push;
        // Empty FIFO: the incoming entry is the head this very cycle.
        rdata = empty ? wdata : mem_q[rd_ptr_q];
        // A push consumed through the bypass in the same cycle is never stored.
        store = push && !(empty && pop);
        deq   = pop && !empty;

        rd_ptr_d = deq   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = store ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        if (store && !deq) count_d = count_q + CW'(1);
        else if (!store && deq) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q] <= wdata;
    end

    // Credit accounting upstream must never push into a full FIFO without a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));
endmodule

// File: rtl/bus2ram_slave.sv
// Bus slave serving RD/WR commands from a synchronous single-port SRAM.
//   clk, reset : clock and synchronous active-high reset
//   bus        : bus slave port (command, write data, responses)
//   mem_*      : SRAM strobe/write/address/byte-enable/data, mem_rdata arrives
//                READ_LATENCY cycles after mem_en
// Commands are accepted against credits (accepted but not yet popped), travel
// a READ_LATENCY-deep pipe in order, and land in a response FIFO whose head
// drives SResp/SData until the master accepts it.
module bus2ram_slave
    import bus2ram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int READ_LATENCY   = 1,
    parameter int RESP_DEPTH     = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    bus2ram_slave_if.slave                  bus,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]       mem_addr,
    output logic [be_width(DATA_WIDTH)-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);
    typedef struct packed {
        Bus::Resp              resp;
        logic [DATA_WIDTH-1:0] data;
    } resp_entry_t;

    localparam int CNT_W   = $clog2(RESP_DEPTH + 1);
    localparam int ENTRY_W = $bits(resp_entry_t);
    localparam int LAST    = READ_LATENCY - 1;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [READ_LATENCY-1:0] pipe_rd_q, pipe_rd_d;
    logic [READ_LATENCY-1:0] pipe_err_q, pipe_err_d;
    logic                    is_rd, is_wr, in_range, cmd_err, cmd_ready, accept, pop;
    resp_entry_t             push_entry, head_entry;
    logic [ENTRY_W-1:0]      fifo_rdata;
    logic                    fifo_valid, fifo_full, fifo_empty;
    logic [CNT_W-1:0]        fifo_count;

    always_comb begin
        is_rd     = (bus.MCmd == Bus::RD);
        is_wr     = (bus.MCmd == Bus::WR);
        // Any byte-address bit above the SRAM word index makes it out of range.
        in_range  = ((bus.MAddr >> (MEM_ADDR_WIDTH + 2)) == '0);
        cmd_err   = !((is_rd || is_wr) && in_range);
        cmd_ready = !reset && (cnt_q < CNT_W'(RESP_DEPTH));
        accept    = cmd_ready && (bus.MCmd != Bus::IDLE);

        // Reset gates cmd_ready, so no SRAM write leaks out of a reset cycle.
        mem_en    = accept && !cmd_err;
        mem_we    = mem_en && is_wr;
        mem_addr  = bus.MAddr[MEM_ADDR_WIDTH+1:2];
        mem_be    = is_wr ? bus.MByteEn : '1;
        mem_wdata = bus.MData;

        // Every accepted command rides the pipe so responses stay in order.
        pipe_vld_d[0] = accept;
        pipe_rd_d[0]  = accept && is_rd && !cmd_err;
        pipe_err_d[0] = accept && cmd_err;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_rd_d[i]  = pipe_rd_q[i-1];
            pipe_err_d[i] = pipe_err_q[i-1];
        end

        push_entry.resp = pipe_err_q[LAST] ? Bus::ERR : Bus::DVA;
        push_entry.data = pipe_rd_q[LAST] ? mem_rdata : '0;

        head_entry      = resp_entry_t'(fifo_rdata);
        bus.SCmdAccept  = cmd_ready;
        bus.SResp       = (fifo_valid && !reset) ? head_entry.resp : Bus::NULL;
        bus.SData       = (fifo_valid && !reset) ? head_entry.data : '0;
        pop             = fifo_valid && !reset && bus.MRespAccept;

        cnt_d = cnt_q;
        if (accept && !pop) cnt_d = cnt_q + CNT_W'(1);
        else if (!accept && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            pipe_vld_q <= '0;
            pipe_rd_q  <= '0;
            pipe_err_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_rd_q  <= pipe_rd_d;
            pipe_err_q <= pipe_err_d;
        end
    end

    bus2ram_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_resp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pipe_vld_q[LAST]),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (fifo_rdata),
        .valid (fifo_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Stored responses are a subset of the outstanding credits.
    a_occupancy: assert property (@(posedge clk) disable iff (reset)
        (fifo_count <= cnt_q) && (fifo_full == (fifo_count == CNT_W'(RESP_DEPTH)))
        && (fifo_empty == (fifo_count == '0)));
endmodule

// File: tb/tb_bus2ram_slave.sv
// Bench for bus2ram_slave: directed vector table, stall/full/reset sequences,
// then random traffic, all cross-checked by a transaction-level model.
module tb_bus2ram_slave;
    localparam int AW = 32, DW = 32, MAW = 10, L = 2, D = 3;

    logic clk = 1'b0;
    logic reset;
    logic mem_en, mem_we;
    logic [MAW-1:0] mem_addr;
    logic [3:0] mem_be;
    logic [DW-1:0] mem_wdata, mem_rdata;

    bus2ram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

    bus2ram_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW),
        .READ_LATENCY(L), .RESP_DEPTH(D)
    ) dut (
        .clk(clk), .reset(reset), .bus(bif),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endfunction

    // SRAM with L-cycle read latency; garbage outside valid read slots.
    logic [31:0] sram [1024] = '{default: 32'h0};
    logic [31:0] rpipe [L];
    always @(posedge clk) begin
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        rpipe[0] <= (mem_en && !mem_we) ? sram[mem_addr] : 32'hBAD0_BAD0;
        for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[L-1];

    // Transaction-level model: outstanding credit count plus a queue of
    // expected responses, each visible from accept cycle + L onwards.
    typedef struct { Bus::Resp r; logic [31:0] d; int rdy; } exp_t;
    exp_t q[$];
    logic [31:0] mm [1024] = '{default: 32'h0};
    int outstanding = 0, mcyc = 0;

    always @(negedge clk) begin : model
        bit exp_acc, vis, acc, good;
        int w;
        exp_t e;
        if (reset) begin
            chk("rst_sresp", bif.SResp, Bus::NULL);
            chk("rst_sdata", bif.SData, 0);
            chk("rst_accept", bif.SCmdAccept, 0);
            chk("rst_mem_en", mem_en, 0);
            q.delete();
            outstanding = 0;
        end else begin
            exp_acc = (outstanding < D);
            chk("m_accept", bif.SCmdAccept, exp_acc);
            vis = (q.size() > 0) && (q[0].rdy <= mcyc);
            chk("m_sresp", bif.SResp, vis ? q[0].r : Bus::NULL);
            chk("m_sdata", bif.SData, vis ? q[0].d : 32'h0);
            acc  = exp_acc && (bif.MCmd != Bus::IDLE);
            good = acc && (bif.MCmd == Bus::RD || bif.MCmd == Bus::WR)
                   && (bif.MAddr < (32'd1 << (MAW + 2)));
            chk("m_mem_en", mem_en, good);
            w = int'(bif.MAddr / 4);
            if (good) begin
                chk("m_mem_addr", mem_addr, w);
                chk("m_mem_we", mem_we, bif.MCmd == Bus::WR);
            end
            if (vis && bif.MRespAccept) begin
                void'(q.pop_front());
                outstanding--;
            end
            if (acc) begin
                e.rdy = mcyc + L;
                e.r = good ? Bus::DVA : Bus::ERR;
                e.d = 32'h0;
                if (good && bif.MCmd == Bus::RD) e.d = mm[w];
                if (good && bif.MCmd == Bus::WR)
                    for (int b = 0; b < 4; b++)
                        if (bif.MByteEn[b]) mm[w][8*b +: 8] = bif.MData[8*b +: 8];
                q.push_back(e);
                outstanding++;
            end
        end
        mcyc++;
    end

    // Drive a command until accepted; returns at posedge+1 after the accept.
    task automatic issue(input Bus::Cmd c, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int ac);
        bit done = 0;
        ac = -1;
        bif.MCmd = c; bif.MAddr = a; bif.MData = d; bif.MByteEn = be;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (bif.SCmdAccept) begin done = 1; ac = cyc; end
            @(posedge clk); #1;
        end
        bif.MCmd = Bus::IDLE;
        chk("issue_timeout", done, 1);
    endtask

    task automatic wait_resp(output Bus::Resp r, output logic [31:0] d, output int rc);
        bit got = 0;
        r = Bus::NULL; d = 0; rc = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (bif.SResp != Bus::NULL) begin got = 1; r = bif.SResp; d = bif.SData; rc = cyc; end
            @(posedge clk); #1;
        end
        chk("resp_timeout", got, 1);
    endtask

    // Fill all credits with stalled reads, hold a 4th read, then release.
    task automatic stall_release(input logic [31:0] a0, a1, a2, a3,
                                 input logic [31:0] e0, e1, e2, e3);
        logic [31:0] got [4];
        logic [31:0] exp [4];
        int ac, n = 0;
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        bif.MRespAccept = 0;
        issue(Bus::RD, a0, 0, 4'hF, ac);
        issue(Bus::RD, a1, 0, 4'hF, ac);
        issue(Bus::RD, a2, 0, 4'hF, ac);
        bif.MCmd = Bus::RD; bif.MAddr = a3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_blocked", bif.SCmdAccept, 0);
            @(posedge clk); #1;
        end
        bif.MRespAccept = 1;
        for (int k = 0; k < 20 && n < 4; k++) begin
            @(negedge clk);
            if (k == 0) chk("pop_cycle_accept", bif.SCmdAccept, 0);
            if (k == 1) chk("reaccept_after_pop", bif.SCmdAccept, 1);
            if (bif.SResp != Bus::NULL) begin got[n] = bif.SData; n++; end
            @(posedge clk); #1;
            if (k == 1) bif.MCmd = Bus::IDLE;
        end
        chk("stall_count", n, 4);
        for (int i = 0; i < 4; i++) chk("stall_order_data", got[i], exp[i]);
    endtask

    typedef struct {
        Bus::Cmd cmd; logic [31:0] addr; logic [31:0] data; logic [3:0] be;
        Bus::Resp er; logic [31:0] ed;
    } vec_t;
    vec_t tbl [13];

    initial begin
        Bus::Resp r;
        logic [31:0] d;
        int ac, rc;

        tbl[0]  = '{Bus::WR, 32'h14, 32'hDEADBEEF, 4'hF, Bus::DVA, 32'h0};
        tbl[1]  = '{Bus::RD, 32'h14, 32'h0, 4'h0, Bus::DVA, 32'hDEADBEEF};
        tbl[2]  = '{Bus::WR, 32'h8, 32'h11223344, 4'b0101, Bus::DVA, 32'h0};
        tbl[3]  = '{Bus::RD, 32'h8, 32'h0, 4'h0, Bus::DVA, 32'h00220044};
        tbl[4]  = '{Bus::RD, 32'h1000, 32'h0, 4'h0, Bus::ERR, 32'h0};
        tbl[5]  = '{Bus::Cmd'(3'd5), 32'h14, 32'h0, 4'hF, Bus::ERR, 32'h0};
        tbl[6]  = '{Bus::RD, 32'h14, 32'h0, 4'h0, Bus::DVA, 32'hDEADBEEF};
        tbl[7]  = '{Bus::WR, 32'hFFC, 32'hAABBCCDD, 4'hF, Bus::DVA, 32'h0};
        tbl[8]  = '{Bus::RD, 32'hFFE, 32'h0, 4'h0, Bus::DVA, 32'hAABBCCDD};
        tbl[9]  = '{Bus::WR, 32'h8, 32'hFFFFFFFF, 4'h0, Bus::DVA, 32'h0};
        tbl[10] = '{Bus::RD, 32'h9, 32'h0, 4'h0, Bus::DVA, 32'h00220044};
        tbl[11] = '{Bus::WR, 32'h80000008, 32'h12345678, 4'hF, Bus::ERR, 32'h0};
        tbl[12] = '{Bus::RD, 32'h8, 32'h0, 4'h0, Bus::DVA, 32'h00220044};

        reset = 1;
        bif.MCmd = Bus::IDLE; bif.MAddr = 0; bif.MData = 0; bif.MByteEn = 0;
        bif.MRespAccept = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_sresp", bif.SResp, Bus::NULL);
        chk("reset_accept", bif.SCmdAccept, 0);
        chk("reset_mem_we", mem_we, 0);
        @(posedge clk); #1;
        reset = 0;

        // Directed vectors, one at a time with an idle FIFO.
        foreach (tbl[i]) begin
            issue(tbl[i].cmd, tbl[i].addr, tbl[i].data, tbl[i].be, ac);
            wait_resp(r, d, rc);
            chk($sformatf("vec%0d_resp", i), r, tbl[i].er);
            chk($sformatf("vec%0d_data", i), d, tbl[i].ed);
            chk($sformatf("vec%0d_latency", i), rc - ac, L);
        end

        stall_release(32'h14, 32'h8, 32'hFFC, 32'h0,
                      32'hDEADBEEF, 32'h00220044, 32'hAABBCCDD, 32'h0);
        stall_release(32'h14, 32'h14, 32'h14, 32'h8,
                      32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00220044);

        // Reset with two responses buffered and one read in the pipe; a write
        // presented during reset must not reach the SRAM.
        bif.MRespAccept = 0;
        issue(Bus::RD, 32'h14, 0, 4'hF, ac);
        issue(Bus::RD, 32'hFFC, 0, 4'hF, ac);
        issue(Bus::RD, 32'h8, 0, 4'hF, ac);
        @(posedge clk); #1;
        reset = 1;
        bif.MCmd = Bus::WR; bif.MAddr = 32'h14; bif.MData = 32'h0; bif.MByteEn = 4'hF;
        @(negedge clk);
        chk("midrst_sresp", bif.SResp, Bus::NULL);
        chk("midrst_accept", bif.SCmdAccept, 0);
        chk("midrst_mem_en", mem_en, 0);
        @(posedge clk); #1;
        reset = 0; bif.MCmd = Bus::IDLE; bif.MRespAccept = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_no_stale", bif.SResp, Bus::NULL);
            @(posedge clk); #1;
        end
        issue(Bus::RD, 32'h14, 0, 4'hF, ac);
        wait_resp(r, d, rc);
        chk("post_rst_resp", r, Bus::DVA);
        chk("post_rst_data", d, 32'hDEADBEEF);

        // Random traffic against the model, with one reset pulse mid-stream.
        for (int k = 0; k < 400; k++) begin
            int sel;
            sel = $urandom_range(0, 9);
            bif.MCmd = (sel < 3) ? Bus::IDLE : (sel < 6) ? Bus::RD :
                       (sel < 9) ? Bus::WR : Bus::Cmd'(3'($urandom_range(3, 7)));
            bif.MAddr = ($urandom_range(0, 11) == 0) ? ($urandom | 32'h1000)
                                                     : 32'($urandom_range(0, 63));
            bif.MData = $urandom;
            bif.MByteEn = 4'($urandom);
            bif.MRespAccept = ($urandom_range(0, 9) < 7);
            reset = (k == 250);
            @(posedge clk); #1;
        end
        reset = 0; bif.MCmd = Bus::IDLE; bif.MRespAccept = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("final_drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bus2ram_slave.md
Name: bus2ram_slave

Overview:
Bus slave that serves read and write commands from the on-chip bus master out of a synchronous single-port SRAM with configurable read latency. It sits directly downstream of the RAM-to-bus bridges and is the endpoint their bus transactions land on. Command acceptance is credit-based. Responses are buffered and held until the master accepts them, so responses are never dropped.

Parameters:
ADDR_WIDTH, 32, bus byte-address width (MAddr)
DATA_WIDTH, 32, bus and memory data width; multiple of 8
MEM_ADDR_WIDTH, 10, SRAM word-address width
READ_LATENCY, 1, SRAM cycles from mem_en to valid mem_rdata (1..4)
RESP_DEPTH, 2, maximum transactions in flight plus buffered responses (>= READ_LATENCY+1 for full throughput)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
MCmd  in  Bus::Cmd  bus command (IDLE/RD/WR/other)
MAddr  in  ADDR_WIDTH  byte address
MData  in  DATA_WIDTH  write data
MByteEn  in  DATA_WIDTH/8  byte enables
MRespAccept  in  1  master accepts the current response
SCmdAccept  out  1  command accepted this cycle when MCmd != IDLE
SResp  out  Bus::Resp  NULL/DVA/ERR
SData  out  DATA_WIDTH  read data; valid with SResp=DVA for reads
mem_en  out  1  SRAM access strobe
mem_we  out  1  SRAM write
mem_addr  out  MEM_ADDR_WIDTH  SRAM word address
mem_be  out  DATA_WIDTH/8  SRAM byte write enables
mem_wdata  out  DATA_WIDTH  SRAM write data
mem_rdata  in  DATA_WIDTH  SRAM read data

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on reset.
- Reset: credit count=0, latency pipe cleared, response FIFO empty. SResp=NULL, SData=0, mem_en=0, mem_we=0, SCmdAccept=0 while reset is high.
- Credits:
  - cnt = commands accepted but not yet popped from the response FIFO.
  - SCmdAccept = !reset && (cnt < RESP_DEPTH); combinational, independent of MCmd.
  - Accept event = SCmdAccept && MCmd != IDLE.
  - Pop event = SResp != NULL && MRespAccept.
  - cnt +1 on accept only, -1 on pop only, unchanged on both in the same cycle.
- Address decode:
  - Word index = MAddr[MEM_ADDR_WIDTH+1:2].
  - Out of range when any MAddr bit above MEM_ADDR_WIDTH+1 is nonzero.
  - MAddr[1:0] is ignored.
- Memory issue: combinational in the accept cycle, only for in-range RD/WR.
  - mem_en=1; mem_we=(MCmd==WR); mem_addr=word index.
  - mem_be=MByteEn for WR, all-ones for RD; mem_wdata=MData.
  - mem_en=0 whenever there is no accept event.
- ERR commands: out-of-range RD/WR and any command other than IDLE/RD/WR.
  - No memory access.
  - Produce an ERR response with data 0.
- Latency pipe: READ_LATENCY stages carrying {valid, is_read, err}.
  - Stage 0 is loaded on every accept; writes and ERR commands travel the same pipe to preserve ordering.
  - On exit, a FIFO entry is pushed: read → {DVA, mem_rdata}; write → {DVA, 0}; err → {ERR, 0}.
- Response FIFO:
  - RESP_DEPTH entries.
  - Head drives SResp/SData; SResp=NULL and SData=0 when empty.
  - Head is held stable until MRespAccept.
  - The credit scheme guarantees no push when full; an assertion checks this.
  - Push and pop in the same cycle are both allowed, including when the FIFO is full before the cycle.
- Latency: a read accepted in cycle t shows SResp=DVA in cycle t+READ_LATENCY when the FIFO is empty and the master is not stalling. Sustained throughput is 1 transaction/cycle when RESP_DEPTH >= READ_LATENCY+1.
- Ordering: responses are returned strictly in command order.
- Reset mid-operation: in-flight and buffered transactions are discarded without responses. The SRAM write issued in the cycle reset asserts is suppressed because mem_en is gated by reset.

Decomposition:
- Package Bus (existing): Cmd enum (IDLE, WR, RD, ...) and Resp enum (NULL, DVA, ERR).
- Add localparam-style helpers there: byte-enable width = DATA_WIDTH/8, and a response-entry struct {Resp, data}.
- One sub-module: bus2ram_resp_fifo, a synchronous FIFO with parameterised depth and width, exposing full, empty and count.

Test Plan:
- Single read:
  - Stimulus: SRAM word 5 = 0xDEADBEEF, READ_LATENCY=1; RD at MAddr=0x14.
  - Response: mem_en=1, mem_addr=5 in cycle t; SResp=DVA, SData=0xDEADBEEF at t+1.
- Byte write then read:
  - Stimulus: WR MAddr=0x8, MData=0x11223344, MByteEn=4'b0101, over initial 0; then RD 0x8.
  - Response: write response DVA with data 0; read data 0x00220044.
- Back-to-back reads with the master stalling:
  - Stimulus: READ_LATENCY=2, RESP_DEPTH=3; 4 RDs issued with MRespAccept=0.
  - Response: SCmdAccept drops after 3 accepts; raising MRespAccept yields 4 in-order DVAs and SCmdAccept reasserts the cycle after the first pop.
- Error paths:
  - Stimulus: RD at MAddr=0x1000 with MEM_ADDR_WIDTH=10; then an unsupported command.
  - Response: no mem_en; SResp=ERR, SData=0 for each; a following valid RD still returns DVA in order.
- Simultaneous accept and pop when full:
  - Stimulus: RESP_DEPTH=2, cnt=2.
  - Response: SCmdAccept=0 until the pop cycle; after the pop, accept, and cnt stays at the correct value with no FIFO overflow assertion.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle with 2 responses buffered and 1 read in the pipe.
  - Response: SResp=NULL and SCmdAccept=0 during reset; no stale response afterwards; the next RD returns correct data.
